// File: rtl/seq_shifter_pkg.sv
// Shared op and FSM state encodings for the sequential shifter and the ALU control decoder.
// Build option SEQ_SHIFTER_ROTR_EN enables the rotate-right op in the shift datapath.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int STEP_W = 4;

  // Step size for this cycle: min(remaining, max_step); max_step is at most 8 so it fits STEP_W.
  function automatic logic [STEP_W-1:0] step_size(input logic [AMT_W-1:0] remaining,
                                                  input int max_step);
    if (int'(remaining) > max_step) begin
      return STEP_W'(max_step);
    end
    return remaining[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single step of the shifter: shifts the working operand by k positions.
// Op 11 rotates right only when SEQ_SHIFTER_ROTR_EN is defined; otherwise it is a logical right shift.
module shift_step
  import seq_shifter_pkg::*;
(
  input  logic [DATA_W-1:0] operand,
  input  sh_op_e            op,
  input  logic [STEP_W-1:0] k,
  output logic [DATA_W-1:0] shifted
);

  always_comb begin
    shifted = operand;
    case (op)
      SH_SLL:  shifted = operand << k;
      // Sign bit is never disturbed by >>>, so it keeps replicating the latched operand's bit 31.
      SH_SRA:  shifted = DATA_W'($signed(operand) >>> k);
`ifdef SEQ_SHIFTER_ROTR_EN
      SH_ROTR: shifted = (operand >> k) | (operand << (6'(DATA_W) - {2'b00, k}));
`endif
      default: shifted = operand >> k;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-less shifter: shifts up to MAX_STEP positions per cycle under a small FSM.
// Define SEQ_SHIFTER_ROTR_EN to make op 11 a rotate right instead of a logical right shift.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int MAX_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [31:0] amt_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  sh_state_e         state_reg;
  sh_op_e            op_reg;
  logic [DATA_W-1:0] work_reg;
  logic [AMT_W-1:0]  remaining_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [STEP_W-1:0] k_step;
  logic [DATA_W-1:0] work_next;

  // Only the low five amount bits are meaningful.
  logic unused_amt;
  assign unused_amt = ^amt_in[31:AMT_W];

  assign k_step = step_size(remaining_reg, MAX_STEP);

  shift_step u_step (
    .operand (work_reg),
    .op      (op_reg),
    .k       (k_step),
    .shifted (work_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= SH_SLL;
      work_reg      <= '0;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            work_reg      <= data_in;
            op_reg        <= sh_op_e'(op);
            remaining_reg <= amt_in[AMT_W-1:0];
            busy_reg      <= 1'b1;
            if (amt_in[AMT_W-1:0] != '0) begin
              state_reg <= ST_SHIFT;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work_reg      <= work_next;
          remaining_reg <= remaining_reg - AMT_W'(k_step);
          if (remaining_reg == AMT_W'(k_step)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Any start seen here is dropped; the first IDLE cycle accepts the next request.
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = work_reg;

endmodule
